activ_sched: RTL and testbench
==============================

# activ_sched

Round-robin scheduler that shares one ReLU datapath and one Sigmoid datapath (Q8.8, 16-bit) between N neuron requesters. Each requester offers a pre-activation value plus a function select. The block grants one requester at a time, holds the operand on the shared activation inputs for a programmable settle window, and captures the result into a registered output with a valid/ready handshake. It sits between the neuron MAC stages and the next-layer input buffer.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- EVAL_CYC, default 1: cycles the operand is held on the activation inputs before the result is captured (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i = requester i has an operand.
- req_data  in  16*N_REQ  Q8.8 operand; slice i = bits [16i+15:16i].
- req_func  in  N_REQ  bit i: 0 = ReLU, 1 = Sigmoid.
- req_ready  out  N_REQ  one-hot grant; operand i accepted on the edge where req_valid[i] & req_ready[i].
- act_x  out  16  operand driven to both shared activation units.
- act_relu_z  in  16  ReLU result for act_x.
- act_sig_z  in  16  Sigmoid result for act_x.
- out_valid  out  1  result available.
- out_data  out  16  captured Q8.8 result.
- out_id  out  clog2(N_REQ)  index of the requester that owns out_data.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in EVAL or DONE.

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE: grant g is the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ. req_ready[g] is driven combinationally, and only for g.
  - On the edge: x_reg←req_data[g], func_reg←req_func[g], id_reg←g, rr_ptr←(g+1) mod N_REQ, cnt←EVAL_CYC-1, go to EVAL.
  - If no req_valid is set: stay in IDLE, req_ready=0.
- EVAL: act_x=x_reg; req_ready=0.
  - If cnt≠0: cnt decrements.
  - If cnt=0: out_data←(func_reg ? act_sig_z : act_relu_z), out_id←id_reg, go to DONE.
- DONE: out_valid=1. out_data and out_id stay stable until out_ready=1; on that edge go to IDLE. req_ready=0 throughout DONE.
- act_x holds x_reg in all states, so the shared units see a stable operand. x_reg resets to 0.
- No arithmetic is performed in the block. Results pass through bit-exact, with no saturation or rounding.
- A requester that drops req_valid before it is granted is simply skipped. A granted operand is never lost.
- rr_ptr advances only on a grant, so starvation is bounded: every valid requester is served within N_REQ grants.

## Timing
- Reset values (asynchronous, any state including mid-EVAL or mid-DONE):
  - state=IDLE, rr_ptr=0, cnt=0.
  - x_reg, out_data, out_id = 0.
  - out_valid=0, busy=0, req_ready=0.
  - An in-flight result is discarded.
- If a grant occurs at edge t:
  - EVAL occupies cycles t+1 .. t+EVAL_CYC.
  - out_valid rises in cycle t+EVAL_CYC+1.
- Minimum service period with out_ready held at 1 is EVAL_CYC+2 cycles per operand (EVAL_CYC=1 gives 3).
- Back-pressure: out_valid stays high and the FSM stalls in DONE for any number of cycles. No new grant is issued while stalled.
- If req_valid changes during IDLE in the same cycle as evaluation, the combinational grant uses the current values.
- out_valid and out_data are registered outputs. req_ready is combinational from req_valid, state and rr_ptr.

## Test plan
- ReLU, single requester, EVAL_CYC=1, out_ready=1: req_valid=0001, data=0x0180, func=0, bench ReLU stub.
  - Expect req_ready=0001 for one cycle, act_x=0x0180, then out_valid 2 cycles after the grant edge with out_data=0x0180, out_id=0.
  - Repeat with data=0xFE80: expect out_data=0x0000.
- Sigmoid path: requester 2, data=0x0080, func=1; bench drives act_sig_z=0x0095 whenever act_x=0x0080.
  - Expect out_data=0x0095, out_id=2.
- Round-robin fairness: req_valid=1111 held continuously, out_ready=1.
  - Expect grant order 0,1,2,3,0,1, each grant 3 cycles apart.
  - Then req_valid=1010 with rr_ptr=2: expect grant 3, then 1.
- Back-pressure: with out_ready=0 for 5 cycles after out_valid rises:
  - out_valid, out_data and out_id stay constant.
  - req_ready stays 0 even though req_valid=1111.
  - Grant resumes in the cycle after the out_ready=1 edge.
- EVAL_CYC=4: the bench changes act_relu_z only in the last EVAL cycle.
  - Expect the captured value to come from that last cycle, and out_valid to rise 5 cycles after the grant edge.
- Asynchronous reset: assert rst mid-EVAL, and separately in DONE.
  - Expect out_valid=0, busy=0, req_ready=0 immediately, with no clock edge needed.
  - After release with req_valid=1111, expect the first grant to be requester 0.

Source files
------------

// File: rtl/activ_sched.sv
`default_nettype none
// ============================================================================
// Module   : activ_sched
// Purpose  : Round-robin arbiter sharing one ReLU and one Sigmoid datapath
//            (Q8.8) between N_REQ requesters, with a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module activ_sched #(
    parameter int N_REQ    = 4,
    parameter int EVAL_CYC = 1,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]     req_func,
    output logic [N_REQ-1:0]     req_ready,
    output logic [15:0]          act_x,
    input  logic [15:0]          act_relu_z,
    input  logic [15:0]          act_sig_z,
    output logic                 out_valid,
    output logic [15:0]          out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0]     C_CNT_INIT = 4'(EVAL_CYC - 1);
    localparam logic [IDW-1:0] C_LAST_ID  = IDW'(N_REQ - 1);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [3:0]     r_cnt;
    logic [15:0]    r_x;
    logic           r_func;
    logic [IDW-1:0] r_id;
    logic [15:0]    r_out_data;
    logic [IDW-1:0] r_out_id;
    logic           r_out_valid;

    logic           w_grant_found;
    logic [IDW-1:0] w_grant_idx;
    logic [N_REQ-1:0] w_ready;

    // Search starts at the round-robin pointer and wraps modulo N_REQ.
    always_comb begin
        int idx;
        idx           = 0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_grant_found && req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = IDW'(idx);
            end
        end
    end

    // Gated by rst so the grant drops immediately on an asynchronous reset.
    always_comb begin
        w_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_grant_found) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_func      <= 1'b0;
            r_id        <= '0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_x      <= req_data[int'(w_grant_idx)*16 +: 16];
                        r_func   <= req_func[w_grant_idx];
                        r_id     <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == C_LAST_ID) ? '0
                                                               : w_grant_idx + IDW'(1);
                        r_cnt    <= C_CNT_INIT;
                        r_state  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_out_data  <= r_func ? act_sig_z : act_relu_z;
                        r_out_id    <= r_id;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign act_x     = r_x;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign busy      = (r_state == S_EVAL) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_activ_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_activ_sched
// Purpose  : Directed self-checking bench for activ_sched (EVAL_CYC 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_activ_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data  = '0;
    logic [3:0]  req_func  = '0;
    logic        out_ready = 1'b1;

    logic [3:0]  ready1, ready4;
    logic [15:0] act_x1, act_x4, relu1, sig1, sig4, od1, od4;
    logic [15:0] relu4 = '0;
    logic [1:0]  oid1, oid4;
    logic        ov1, ov4, busy1, busy4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Activation stubs: ReLU clamps negatives, sigmoid answers 0x0095 for 0x0080.
    assign relu1 = act_x1[15] ? 16'h0000 : act_x1;
    assign sig1  = (act_x1 == 16'h0080) ? 16'h0095 : 16'h7777;
    assign sig4  = 16'h0000;

    activ_sched #(.N_REQ(4), .EVAL_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_func(req_func), .req_ready(ready1), .act_x(act_x1),
        .act_relu_z(relu1), .act_sig_z(sig1), .out_valid(ov1), .out_data(od1),
        .out_id(oid1), .out_ready(out_ready), .busy(busy1)
    );

    activ_sched #(.N_REQ(4), .EVAL_CYC(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_func(req_func), .req_ready(ready4), .act_x(act_x4),
        .act_relu_z(relu4), .act_sig_z(sig4), .out_valid(ov4), .out_data(od4),
        .out_id(oid4), .out_ready(out_ready), .busy(busy4)
    );

    task automatic do_reset();
        req_valid = '0; req_func = '0; req_data = '0; out_ready = 1'b1; relu4 = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_checks++; if (ready1 !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", ready1); else n_pass++;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy1); else n_pass++;
        n_checks++; if (act_x1 !== 16'h0000) $display("FAIL reset_act_x: got %h expected 0000", act_x1); else n_pass++;
        n_checks++; if (od1 !== 16'h0000 || oid1 !== 2'd0) $display("FAIL reset_out: got %h/%0d expected 0000/0", od1, oid1); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_relu();
        logic [15:0] din [2];
        logic [15:0] dexp [2];
        din  = '{16'h0180, 16'hFE80};
        dexp = '{16'h0180, 16'h0000};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req_data[15:0] = din[i];
            req_valid = 4'b0001;
            #1;
            n_checks++; if (ready1 !== 4'b0001) $display("FAIL relu_grant%0d: got %b expected 0001", i, ready1); else n_pass++;
            @(negedge clk);
            req_valid = '0;
            #1;
            n_checks++; if (ready1 !== 4'b0000 || busy1 !== 1'b1 || ov1 !== 1'b0)
                $display("FAIL relu_eval%0d: ready %b busy %b valid %b expected 0000 1 0", i, ready1, busy1, ov1); else n_pass++;
            n_checks++; if (act_x1 !== din[i]) $display("FAIL relu_act_x%0d: got %h expected %h", i, act_x1, din[i]); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (ov1 !== 1'b1 || od1 !== dexp[i] || oid1 !== 2'd0)
                $display("FAIL relu_result%0d: valid %b data %h id %0d expected 1 %h 0", i, ov1, od1, oid1, dexp[i]); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (ov1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL relu_idle%0d: valid %b busy %b expected 0 0", i, ov1, busy1); else n_pass++;
        end
    endtask

    task automatic test_sigmoid();
        do_reset();
        req_data[47:32] = 16'h0080;
        req_func  = 4'b0100;
        req_valid = 4'b0100;
        #1;
        n_checks++; if (ready1 !== 4'b0100) $display("FAIL sig_grant: got %b expected 0100", ready1); else n_pass++;
        @(negedge clk);
        req_valid = '0; req_func = '0;
        #1;
        n_checks++; if (act_x1 !== 16'h0080) $display("FAIL sig_act_x: got %h expected 0080", act_x1); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (ov1 !== 1'b1 || od1 !== 16'h0095 || oid1 !== 2'd2)
            $display("FAIL sig_result: valid %b data %h id %0d expected 1 0095 2", ov1, od1, oid1); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_id [8];
        exp_id = '{0, 1, 2, 3, 0, 1, 3, 1};
        do_reset();
        req_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 6) ? 4'b1111 : 4'b1010;
            #1;
            n_checks++; if (ready1 !== 4'(1 << exp_id[i])) $display("FAIL rr_grant%0d: got %b expected %b", i, ready1, 4'(1 << exp_id[i])); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (ready1 !== 4'b0000 || ov1 !== 1'b0) $display("FAIL rr_eval%0d: ready %b valid %b expected 0000 0", i, ready1, ov1); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (ov1 !== 1'b1 || oid1 !== 2'(exp_id[i]) || od1 !== 16'((exp_id[i] + 1) * 256))
                $display("FAIL rr_result%0d: valid %b id %0d data %h expected 1 %0d %h", i, ov1, oid1, od1, exp_id[i], 16'((exp_id[i] + 1) * 256)); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #1;
        n_checks++; if (ready1 !== 4'b0001) $display("FAIL bp_grant: got %b expected 0001", ready1); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (ov1 !== 1'b1 || od1 !== 16'h0100 || oid1 !== 2'd0)
            $display("FAIL bp_rise: valid %b data %h id %0d expected 1 0100 0", ov1, od1, oid1); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if (ov1 !== 1'b1 || od1 !== 16'h0100 || oid1 !== 2'd0 || ready1 !== 4'b0000 || busy1 !== 1'b1)
                $display("FAIL bp_hold%0d: valid %b data %h id %0d ready %b busy %b expected 1 0100 0 0000 1", c, ov1, od1, oid1, ready1, busy1); else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (ready1 !== 4'b0010 || ov1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL bp_resume: ready %b valid %b busy %b expected 0010 0 0", ready1, ov1, busy1); else n_pass++;
    endtask

    task automatic test_eval4();
        do_reset();
        relu4 = 16'h1111;
        req_data[15:0] = 16'h0180;
        req_valid = 4'b0001;
        #1;
        n_checks++; if (ready4 !== 4'b0001) $display("FAIL e4_grant: got %b expected 0001", ready4); else n_pass++;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c < 5) begin
                n_checks++; if (busy4 !== 1'b1 || ov4 !== 1'b0 || act_x4 !== 16'h0180)
                    $display("FAIL e4_eval%0d: busy %b valid %b act_x %h expected 1 0 0180", c, busy4, ov4, act_x4); else n_pass++;
                if (c == 4) relu4 = 16'h0ABC;
            end else begin
                n_checks++; if (ov4 !== 1'b1 || od4 !== 16'h0ABC || oid4 !== 2'd0)
                    $display("FAIL e4_result: valid %b data %h id %0d expected 1 0abc 0", ov4, od4, oid4); else n_pass++;
                relu4 = 16'h2222;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req_data[15:0] = 16'h0180;
        req_valid = 4'b0001;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ov1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 4'b0000 || act_x1 !== 16'h0000)
            $display("FAIL ar_eval: valid %b busy %b ready %b act_x %h expected 0 0 0000 0000", ov1, busy1, ready1, act_x1); else n_pass++;
        @(negedge clk);
        req_valid = 4'b1111;
        rst = 1'b0;
        #1;
        n_checks++; if (ready1 !== 4'b0001) $display("FAIL ar_eval_regrant: got %b expected 0001", ready1); else n_pass++;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (ov1 !== 1'b1) $display("FAIL ar_done_entry: got %b expected 1", ov1); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ov1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 4'b0000 || od1 !== 16'h0000 || oid1 !== 2'd0)
            $display("FAIL ar_done: valid %b busy %b ready %b data %h id %0d expected 0 0 0000 0000 0", ov1, busy1, ready1, od1, oid1); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (ready1 !== 4'b0001) $display("FAIL ar_done_regrant: got %b expected 0001", ready1); else n_pass++;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_relu();
        test_sigmoid();
        test_round_robin();
        test_backpressure();
        test_eval4();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
